// File: rtl/swgen_pkg.sv
// Shared types for the switch generator sequencer.
// FSM state encoding and seed target codes.
package swgen_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STEP_C = 3'd1,
      SEL    = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_CTRL = 2'd0;
   localparam logic [1:0] SEL_A    = 2'd1;
   localparam logic [1:0] SEL_B    = 2'd2;
   localparam logic [1:0] SEL_RSVD = 2'd3;

endpackage

// File: rtl/swgen_out_hold.sv
// Output bit hold register for the keystream port.
// Holds valid/bit until the consumer takes it.
module swgen_out_hold (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic bit_in,
   input  logic ready,
   output logic valid,
   output logic bit_out,
   output logic fire
);

   assign fire = valid & ready;

   // capture a new bit on load, drop valid once it is taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         bit_out <= 1'b0;
      end else if (load) begin
         valid   <= 1'b1;
         bit_out <= bit_in;
      end else if (fire) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/switch_gen_sequencer.sv
// Sequencer for a clock-controlled two-LFSR keystream generator.
// Define SWGEN_ONES_CNT_EN to build the saturating ones counter.
module switch_gen_sequencer
   import swgen_pkg::*;
#(
   parameter int N  = 8,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          seed_valid,
   output logic          seed_ready,
   input  logic [1:0]    seed_sel,
   input  logic [N-1:0]  seed_data,
   output logic          load_en,
   output logic [1:0]    load_sel,
   output logic [N-1:0]  load_data,
   output logic          step_c,
   output logic          step_a,
   output logic          step_b,
   input  logic          ctrl_bit,
   input  logic          a_bit,
   input  logic          b_bit,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic [LW-1:0] ones_cnt
);

   state_t        state;
   state_t        state_nx;
   logic [2:0]    mask;
   logic [LW-1:0] remaining;
   logic          sel;
   logic          sel_now;
   logic          seed_acc;
   logic          seed_ld;
   logic          start_acc;
   logic          hold_load;
   logic          fire;

   assign seed_acc  = seed_valid & seed_ready;
   assign seed_ld   = seed_acc & (seed_sel != SEL_RSVD);
   assign start_acc = (state == IDLE) & start
                    & (mask == 3'b111) & ~seed_acc;
   assign sel_now   = (state == SEL) ? ctrl_bit : sel;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start_acc)
               state_nx = (len == '0) ? DONE : STEP_C;
         end
         STEP_C: state_nx = SEL;
         SEL:    state_nx = EMIT;
         EMIT: begin
            if (fire)
               state_nx = (remaining == LW'(1)) ? DONE : STEP_C;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // per-state control outputs
   always_comb begin
      seed_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      step_c     = 1'b0;
      step_a     = 1'b0;
      step_b     = 1'b0;
      hold_load  = 1'b0;
      unique case (state)
         IDLE:   seed_ready = 1'b1;
         STEP_C: begin
            busy   = 1'b1;
            step_c = 1'b1;
         end
         SEL: begin
            busy      = 1'b1;
            step_a    = sel_now;
            step_b    = ~sel_now;
            hold_load = 1'b1;
         end
         EMIT:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // seed intake: load pulse to the generator and seeded mask
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask      <= 3'b000;
         load_en   <= 1'b0;
         load_sel  <= SEL_CTRL;
         load_data <= '0;
      end else begin
         load_en <= seed_ld;
         if (seed_ld) begin
            load_sel       <= seed_sel;
            load_data      <= seed_data;
            mask[seed_sel] <= 1'b1;
         end
      end
   end

   // run length and latched branch select
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         remaining <= '0;
         sel       <= 1'b0;
      end else begin
         if (start_acc)  remaining <= len;
         else if (fire)  remaining <= remaining - LW'(1);
         if (state == SEL) sel <= ctrl_bit;
      end
   end

   swgen_out_hold u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (hold_load),
      .bit_in  (sel_now ? a_bit : b_bit),
      .ready   (out_ready),
      .valid   (out_valid),
      .bit_out (out_bit),
      .fire    (fire)
   );

`ifdef SWGEN_ONES_CNT_EN
   logic [LW-1:0] ones_q;

   // saturating count of emitted ones, cleared per run
   always_ff @(posedge clk) begin
      if (!rst_n)
         ones_q <= '0;
      else if (start_acc && (len != '0))
         ones_q <= '0;
      else if (fire && out_bit && (ones_q != '1))
         ones_q <= ones_q + LW'(1);
   end

   assign ones_cnt = ones_q;
`else
   assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_gen_sequencer.sv
// Randomised self-checking bench for switch_gen_sequencer.
// Keystream predicted from seeds by a software generator model.
module tb_switch_gen_sequencer;

   localparam int N  = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          seed_valid = 1'b0;
   logic          seed_ready;
   logic [1:0]    seed_sel = 2'd0;
   logic [N-1:0]  seed_data = '0;
   logic          load_en;
   logic [1:0]    load_sel;
   logic [N-1:0]  load_data;
   logic          step_c, step_a, step_b;
   logic          ctrl_bit, a_bit, b_bit;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy, done;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_bit;
   logic [LW-1:0] ones_cnt;

   always #5 clk = ~clk;

   switch_gen_sequencer #(.N(N), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed_sel(seed_sel), .seed_data(seed_data),
      .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
      .step_c(step_c), .step_a(step_a), .step_b(step_b),
      .ctrl_bit(ctrl_bit), .a_bit(a_bit), .b_bit(b_bit),
      .start(start), .len(len), .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .ones_cnt(ones_cnt)
   );

   function automatic logic [7:0] nx(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // external generator LFSRs driven by the DUT pulses
   logic [7:0] rc = 8'h00, ra = 8'h00, rb = 8'h00;
   logic       force_on = 1'b0;

   always @(posedge clk) begin
      if (load_en) begin
         case (load_sel)
            2'd0:    rc <= load_data;
            2'd1:    ra <= load_data;
            2'd2:    rb <= load_data;
            default: ;
         endcase
      end
      if (step_c) rc <= nx(rc);
      if (step_a) ra <= nx(ra);
      if (step_b) rb <= nx(rb);
   end

   assign ctrl_bit = force_on ? 1'b1 : rc[7];
   assign a_bit    = force_on ? 1'b1 : ra[7];
   assign b_bit    = force_on ? 1'b0 : rb[7];

   // model state
   logic [7:0] mc = 8'h00, ma = 8'h00, mb = 8'h00;
   logic       exp_bits [256];
   int         exp_lim = 0;
   int         exp_ones = 0;

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int n_out = 0, n_stepc = 0, n_stepab = 0, n_busy = 0;
   int n_done = 0, n_hold = 0;
   int first_sc = -1, done_cyc = -1;
   logic [7:0] rx_hist = '0;
   logic prev_stall = 1'b0, prev_bit = 1'b0;
   logic pend_ld = 1'b0;
   logic [1:0] pend_sel = '0;
   logic [7:0] pend_data = '0;
   logic sr_s = 1'b0, ov_s = 1'b0, sc_s = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   // plan the next len output bits from the model generator
   task automatic plan(input int l);
      logic s, b;
      exp_ones = 0;
      for (int k = 0; k < l; k++) begin
         if (force_on) begin
            b = 1'b1;
            mc = nx(mc);
            ma = nx(ma);
         end else begin
            mc = nx(mc);
            s  = mc[7];
            b  = s ? ma[7] : mb[7];
            if (s) ma = nx(ma);
            else   mb = nx(mb);
         end
         exp_bits[(n_out + k) % 256] = b;
         exp_ones += int'(b);
      end
      exp_lim = n_out + l;
   endtask

   // one cycle: sample just after the falling edge, then advance
   task automatic tick();
      int k;
      #1;
      if (chk_en) begin
         k = $countones({step_c, step_a, step_b, load_en});
         chk("pulse_excl", 32'(k <= 1), 1);
         chk("load_en", load_en, pend_ld);
         if (load_en) begin
            chk("load_sel", load_sel, pend_sel);
            chk("load_data", load_data, pend_data);
         end
         if (step_a | step_b) chk("sel_step", step_a, ctrl_bit);
         if (busy | done) chk("seed_ready", seed_ready, 0);
         if (step_c | step_a | step_b | out_valid) chk("busy", busy, 1);
         if (prev_stall) begin
            n_hold++;
            chk("hold_valid", out_valid, 1);
            chk("hold_bit", out_bit, prev_bit);
            chk("stall_step", step_c | step_a | step_b, 0);
         end
         if (out_valid && out_ready) begin
            chk("out_in_run", 32'(n_out < exp_lim), 1);
            if (n_out < exp_lim)
               chk("out_bit", out_bit, exp_bits[n_out % 256]);
            rx_hist = {rx_hist[6:0], out_bit};
            n_out++;
         end
`ifndef SWGEN_ONES_CNT_EN
         chk("ones_off", ones_cnt, 0);
`endif
         if (step_c) begin
            n_stepc++;
            if (first_sc < 0) first_sc = cyc;
         end
         if (step_a | step_b) n_stepab++;
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
      pend_ld    = rst_n & seed_valid & seed_ready & (seed_sel != 2'd3);
      pend_sel   = seed_sel;
      pend_data  = seed_data;
      sr_s       = seed_ready;
      ov_s       = out_valid;
      sc_s       = step_c;
      prev_stall = out_valid & ~out_ready & rst_n;
      prev_bit   = out_bit;
      cyc++;
      @(negedge clk);
   endtask

   task automatic send_seed(input logic [1:0] s, input logic [7:0] d);
      seed_valid = 1'b1;
      seed_sel   = s;
      seed_data  = d;
      sr_s       = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (sr_s) break;
      end
      chk("seed_accept", sr_s, 1);
      seed_valid = 1'b0;
      if (sr_s) begin
         case (s)
            2'd0:    mc = d;
            2'd1:    ma = d;
            2'd2:    mb = d;
            default: ;
         endcase
      end
   endtask

   task automatic wait_done(input int bound, input bit rnd, input bit jam);
      int nd;
      nd = n_done;
      for (int i = 0; i < bound; i++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (jam) begin
            start = 1'b1;
            len   = LW'($urandom_range(1, 20));
         end
         tick();
         if (n_done != nd) break;
      end
      start = 1'b0;
      chk("done_seen", n_done - nd, 1);
   endtask

   task automatic check_ones(input int e);
`ifdef SWGEN_ONES_CNT_EN
      chk("ones_cnt", ones_cnt, e);
`else
      chk("ones_cnt", ones_cnt, e * 0);
`endif
   endtask

   int o0, c0, a0, b0, d0, h0, sc, l;

   initial begin
      // reset
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_bit", out_bit, 0);
      chk("rst_steps", {step_c, step_a, step_b}, 0);
      chk("rst_load", {load_en, load_sel, load_data}, 0);
      chk("rst_ones", ones_cnt, 0);
      chk("rst_seed_ready", seed_ready, 1);
      rst_n = 1'b1;
      tick();

      // partial seeding (reserved code does not count) -> start ignored
      send_seed(2'd0, 8'h11);
      send_seed(2'd1, 8'h22);
      send_seed(2'd3, 8'h33);
      b0 = n_busy; c0 = n_stepc; a0 = n_stepab; d0 = n_done;
      start = 1'b1; len = 16'd5;
      tick();
      start = 1'b0;
      repeat (15) tick();
      chk("part_busy", n_busy - b0, 0);
      chk("part_stepc", n_stepc - c0, 0);
      chk("part_stepab", n_stepab - a0, 0);
      chk("part_done", n_done - d0, 0);

      // hand-checked keystream, len 4, steady ready
      send_seed(2'd0, 8'h50);
      send_seed(2'd1, 8'h80);
      send_seed(2'd2, 8'h40);
      plan(4);
      chk("model_ks", {exp_bits[n_out % 256], exp_bits[(n_out + 1) % 256],
                       exp_bits[(n_out + 2) % 256],
                       exp_bits[(n_out + 3) % 256]}, 4'b1001);
      o0 = n_out; c0 = n_stepc; a0 = n_stepab;
      first_sc = -1;
      out_ready = 1'b1;
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0;
      wait_done(40, 1'b0, 1'b0);
      chk("run4_latency", done_cyc - first_sc, 12);
      chk("run4_outs", n_out - o0, 4);
      chk("run4_stepc", n_stepc - c0, 4);
      chk("run4_stepab", n_stepab - a0, 4);
      chk("run4_bits", rx_hist[3:0], 4'b1001);
      check_ones(2);

      // stall on the first output of a len 3 run
      plan(3);
      o0 = n_out; h0 = n_hold;
      out_ready = 1'b0;
      start = 1'b1; len = 16'd3;
      tick();
      start = 1'b0;
      ov_s = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ov_s) break;
      end
      chk("stall_valid", ov_s, 1);
      repeat (5) tick();
      out_ready = 1'b1;
      wait_done(40, 1'b0, 1'b0);
      chk("stall_len", 32'((n_hold - h0) >= 5), 1);
      chk("stall_outs", n_out - o0, 3);
      check_ones(exp_ones);

      // zero length run
      plan(0);
      c0 = n_stepc; a0 = n_stepab;
      start = 1'b1; len = 16'd0;
      sc = cyc;
      tick();
      start = 1'b0;
      wait_done(5, 1'b0, 1'b0);
      chk("len0_latency", done_cyc - sc, 1);
      chk("len0_steps", (n_stepc - c0) + (n_stepab - a0), 0);

      // randomised runs, occasional reseed, start jammed while busy
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int s = 0; s < 4; s++)
               send_seed(2'($urandom_range(0, 3)), 8'($urandom));
         end
         l = $urandom_range(1, 12);
         plan(l);
         o0 = n_out; c0 = n_stepc;
         start = 1'b1; len = LW'(l);
         tick();
         wait_done(400, 1'b1, 1'b1);
         out_ready = 1'b1;
         chk("rnd_outs", n_out - o0, l);
         chk("rnd_stepc", n_stepc - c0, l);
         check_ones(exp_ones);
      end

      // forced generator bits: every output is a one
      force_on = 1'b1;
      plan(5);
      o0 = n_out;
      start = 1'b1; len = 16'd5;
      tick();
      start = 1'b0;
      wait_done(40, 1'b0, 1'b0);
      chk("force_outs", n_out - o0, 5);
      chk("force_bits", rx_hist[4:0], 5'b11111);
      check_ones(5);
      force_on = 1'b0;
      tick();

      // reset during SEL of a len 10 run
      plan(10);
      start = 1'b1; len = 16'd10;
      tick();
      start = 1'b0;
      sc_s = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sc_s) break;
      end
      chk("pre_rst_stepc", sc_s, 1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_zero", {busy, done, out_valid, out_bit, step_c,
                           step_a, step_b, load_en}, 0);
      chk("mid_rst_ones", ones_cnt, 0);
      rst_n = 1'b1;
      exp_lim = n_out;
      b0 = n_busy; d0 = n_done;
      start = 1'b1; len = 16'd3;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("post_rst_busy", n_busy - b0, 0);
      chk("post_rst_done", n_done - d0, 0);

      // reseed and recover
      send_seed(2'd2, 8'h9C);
      send_seed(2'd0, 8'h3B);
      send_seed(2'd1, 8'hE4);
      plan(6);
      o0 = n_out;
      start = 1'b1; len = 16'd6;
      tick();
      start = 1'b0;
      wait_done(60, 1'b0, 1'b0);
      chk("recover_outs", n_out - o0, 6);
      check_ones(exp_ones);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_gen_sequencer.md
SWITCH_GEN_SEQUENCER -- requirements
Module: switch_gen_sequencer

Interface
REQ-001 Parameter: N, default 8, width of each LFSR seed/state word.
REQ-002 Parameter: LW, default 16, width of the run-length request and counters.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 seed_valid / seed_ready  input / output  1 / 1  seed handshake; transfer when both are high on a clk edge.
REQ-006 seed_sel  input  2  seed target: 0 = control LFSR, 1 = LFSR A, 2 = LFSR B, 3 = reserved.
REQ-007 seed_data  input  N  seed word.
REQ-008 load_en / load_sel / load_data  output  1 / 2 / N  one-cycle load pulse, target and word to the generator LFSRs.
REQ-009 step_c / step_a / step_b  output  1 each  one-cycle advance pulses to the control, A and B LFSRs.
REQ-010 ctrl_bit / a_bit / b_bit  input  1 each  current output bit (state bit N-1) of each LFSR.
REQ-011 start / len  input  1 / LW  run request and requested number of output bits.
REQ-012 busy / done  output  1 / 1  run in progress; one-cycle completion pulse.
REQ-013 out_valid / out_ready / out_bit  output / input / output  1 / 1 / 1  output keystream handshake.
REQ-014 ones_cnt  output  LW  count of 1 bits emitted in the current or last run.

Function
REQ-015 FSM states are IDLE, STEP_C, SEL, EMIT and DONE.
REQ-016 seed_ready shall be 1 only in IDLE.
REQ-017 An accepted seed with seed_sel 0-2 shall produce load_en=1 with that load_sel and load_data on the next cycle, and shall set the matching bit of a 3-bit seeded mask.
REQ-018 An accepted seed with seed_sel 3 shall be consumed without a load pulse and without changing the mask.
REQ-019 In IDLE, start is accepted only when the mask is 3'b111 and no seed transfer occurs in the same cycle; otherwise start is ignored.
REQ-020 Accepted start with len=0 shall go IDLE->DONE with no step pulses.
REQ-021 Accepted start with len>0 shall latch len into remaining, clear ones_cnt and go to STEP_C.
REQ-022 STEP_C: pulse step_c for one cycle, then go to SEL.
REQ-023 SEL: latch sel=ctrl_bit, pulse step_a if sel=1 else step_b, then go to EMIT.
REQ-024 EMIT entry: register out_bit = sel ? a_bit : b_bit and assert out_valid.
REQ-025 out_valid and out_bit shall hold stable until out_ready=1; no step pulse shall occur while an output is pending.
REQ-026 On each output handshake: decrement remaining and increment ones_cnt if out_bit=1; if remaining becomes 0 go to DONE, else go to STEP_C.
REQ-027 Sustained output rate shall be one bit per 3 cycles when out_ready=1.
REQ-028 busy shall be 1 in STEP_C, SEL and EMIT.
REQ-029 DONE: pulse done for one cycle, then return to IDLE; the mask is retained so a later start continues the keystream.
REQ-030 start asserted while busy shall be ignored; len is sampled only at acceptance.
REQ-031 At most one of step_c, step_a, step_b and load_en shall be high in any cycle.

Reset
REQ-032 While rst_n=0 at a clk edge: state=IDLE, mask=0, remaining=0, ones_cnt=0, sel=0, and all step, load, done, busy and out_valid outputs = 0; out_bit=0, load_sel=0, load_data=0.
REQ-033 A reset mid-run shall abandon the run with no further pulses; the generator shall be reseeded before the next start.

Configuration
REQ-034 Macro SWGEN_ONES_CNT_EN: when defined, ones_cnt counts as in REQ-026 and saturates at 2^LW-1; when undefined, ones_cnt is tied to 0 and its counter is not built.

Structure
REQ-035 Package swgen_pkg shall hold the FSM state enum and the seed_sel codes SEL_CTRL=0, SEL_A=1, SEL_B=2, SEL_RSVD=3.
REQ-036 One sub-module, swgen_out_hold, shall implement the out_valid/out_bit hold register and its handshake.

Verification
REQ-037 Seed 0, 1, 2 in turn, then start with len=4 and out_ready=1 -> exactly 4 step_c pulses, 4 step_a/step_b pulses matching ctrl_bit, 4 outputs, done 12 cycles after STEP_C entry.
REQ-038 Start with only seeds 0 and 1 loaded -> start ignored, busy stays 0, no step pulses.
REQ-039 len=3 with out_ready=0 held for 5 cycles on the first output -> out_bit stable, no step pulses during the stall, run completes after release.
REQ-040 Start with len=0 and all seeds loaded -> done pulse 1 cycle after acceptance, no step pulses.
REQ-041 rst_n=0 during SEL of a len=10 run -> all outputs 0 the next cycle, mask=0, and a following start is ignored.
REQ-042 With SWGEN_ONES_CNT_EN defined and a_bit=1, b_bit=0, ctrl_bit=1 forced over len=5 -> ones_cnt=5; with the macro undefined -> ones_cnt=0.
